// File: rtl/logic_op_arbiter.sv
// ---------------------------------------------------------------------------
// logic_op_arbiter
//
// Purpose:
//   Shares one registered bitwise logic unit (NOT/AND/OR/XOR) between
//   NUM_REQ requesters. A round-robin pointer picks one valid requester while
//   the unit is idle. The winner's operands are latched, evaluated one cycle
//   later and then presented, tagged with the winner's index, on a
//   valid/ready response port until the consumer takes them.
//
// Ports:
//   clk         in   1              rising-edge clock
//   rst         in   1              asynchronous, active-high reset
//   req_valid   in   NUM_REQ        per-requester request valid
//   req_ready   out  NUM_REQ        one-hot grant (combinational, IDLE only)
//   req_op      in   2*NUM_REQ      opcode, requester i at [2i+1:2i]
//   req_a       in   WIDTH*NUM_REQ  operand A, requester i at [WIDTH*i +: WIDTH]
//   req_b       in   WIDTH*NUM_REQ  operand B, packed like req_a
//   resp_valid  out  1              result available
//   resp_ready  in   1              consumer takes the result
//   resp_data   out  WIDTH          result
//   resp_id     out  ID_W           index of the requester owning resp_data
//   busy        out  1              high whenever the unit is not idle
//
// Opcodes: 00 = ~a, 01 = a & b, 10 = a | b, 11 = a ^ b.
// ---------------------------------------------------------------------------
module logic_op_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [ID_W-1:0]          resp_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;

  logic [1:0]        r_op_p0;
  logic [WIDTH-1:0]  r_a_p0;
  logic [WIDTH-1:0]  r_b_p0;
  logic [ID_W-1:0]   r_win_p0;

  logic [WIDTH-1:0]  r_data_p1;
  logic [ID_W-1:0]   r_id_p1;

  logic [ID_W-1:0]   w_scan;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_any;
  logic [NUM_REQ-1:0] w_grant;
  logic              w_accept;
  logic              w_consume;

  function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    case (op)
      2'b00:   res = ~a;
      2'b01:   res = a & b;
      2'b10:   res = a | b;
      default: res = a ^ b;
    endcase
    return res;
  endfunction

  // Modulo-NUM_REQ increment; also correct when NUM_REQ is not a power of two.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
    logic [ID_W-1:0] res;
    if (int'(idx) == NUM_REQ - 1) res = '0;
    else                          res = idx + ID_W'(1);
    return res;
  endfunction

  // Round-robin search: walk rr_ptr, rr_ptr+1, ... and keep the first valid.
  always_comb begin
    w_scan      = r_rr_ptr;
    w_grant_idx = '0;
    w_any       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req_valid[w_scan]) begin
        w_any       = 1'b1;
        w_grant_idx = w_scan;
      end
      w_scan = next_idx(w_scan);
    end
  end

  // Grant is only offered while idle; rst masks it so it drops immediately.
  always_comb begin
    w_grant = '0;
    if (w_any && (r_state == IDLE) && !rst) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_consume = (r_state == RESP) && resp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = EXEC;
      EXEC:                   w_state_nxt = RESP;
      RESP:    if (w_consume) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_consume) r_rr_ptr <= next_idx(r_win_p0);
    end
  end

  // Stage p0: capture the winner's request; requesters may change afterwards.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op_p0  <= req_op[2*int'(w_grant_idx) +: 2];
      r_a_p0   <= req_a[WIDTH*int'(w_grant_idx) +: WIDTH];
      r_b_p0   <= req_b[WIDTH*int'(w_grant_idx) +: WIDTH];
      r_win_p0 <= w_grant_idx;
    end
  end

  // Stage p1: evaluate once in EXEC; result holds through RESP and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_p1 <= '0;
      r_id_p1   <= '0;
    end else if (r_state == EXEC) begin
      r_data_p1 <= logic_op(r_op_p0, r_a_p0, r_b_p0);
      r_id_p1   <= r_win_p0;
    end
  end

  assign req_ready  = w_grant;
  assign resp_valid = (r_state == RESP);
  assign resp_data  = r_data_p1;
  assign resp_id    = r_id_p1;
  assign busy       = (r_state != IDLE);

endmodule
